// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl
//   Initiator-side controller for the word-organised data memory `dm`.
//   It accepts byte/half/word loads and stores from the CPU memory stage and
//   drives the dm port. Loads get lane extraction with sign or zero
//   extension. Sub-word stores are done as read-modify-write, because dm
//   only writes whole words.
//
// Ports
//   clock, reset        : single clock; synchronous, active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_write           : 1 = store, 0 = load
//   req_size            : 00 byte, 01 half, 10 word, 11 illegal
//   req_signed          : sign-extend loads
//   req_addr            : byte address
//   req_wdata           : store data, low-aligned
//   resp_valid          : one-cycle completion pulse
//   resp_error          : misaligned or illegal-size request
//   resp_rdata          : load result; holds across stores, errors and idle
//   DM_enable/DM_read/DM_write/DM_address/DMin : outputs to dm
//   DMout               : read data from dm, valid the cycle after a read
module dm_access_ctrl #(
  parameter int data_size    = 32,
  parameter int mem_size_bit = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [mem_size_bit-1:0] req_addr,
  input  logic [data_size-1:0]    req_wdata,
  output logic                    resp_valid,
  output logic                    resp_error,
  output logic [data_size-1:0]    resp_rdata,
  output logic                    DM_enable,
  output logic                    DM_read,
  output logic                    DM_write,
  output logic [mem_size_bit-1:0] DM_address,
  output logic [data_size-1:0]    DMin,
  input  logic [data_size-1:0]    DMout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDW,
    S_WR,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [1:0]              size_q, size_d;
  logic                    signed_q, signed_d;
  logic [1:0]              lane_q, lane_d;
  logic [15:0]             wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [mem_size_bit-1:0] dm_addr_q, dm_addr_d;
  logic [data_size-1:0]    dmin_q, dmin_d;
  logic [data_size-1:0]    rdata_q, rdata_d;
  logic                    req_err;

  // Pick the addressed lane out of a word, then sign or zero extend it.
  function automatic logic [data_size-1:0] load_extract(
    input logic [data_size-1:0] w,
    input logic [1:0]           sz,
    input logic [1:0]           lane,
    input logic                 sgn
  );
    logic [7:0]           b;
    logic [15:0]          h;
    logic [data_size-1:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   r = {{(data_size-8){sgn & b[7]}}, b};
      2'b01:   r = {{(data_size-16){sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of the read word with the store data.
  function automatic logic [data_size-1:0] store_merge(
    input logic [data_size-1:0] w,
    input logic [1:0]           sz,
    input logic [1:0]           lane,
    input logic [15:0]          wd
  );
    logic [data_size-1:0] m;
    m = w;
    if (sz == 2'b00) m[{lane, 3'b000} +: 8]     = wd[7:0];
    else             m[{lane[1], 4'b0000} +: 16] = wd;
    return m;
  endfunction

  always_comb begin
    req_err = (req_size == 2'b11) ||
              ((req_size == 2'b01) && req_addr[0]) ||
              ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    size_d    = size_q;
    signed_d  = signed_q;
    lane_d    = lane_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    dm_addr_d = dm_addr_q;
    dmin_d    = dmin_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          lane_d   = req_addr[1:0];
          wdata_d  = req_wdata[15:0];
          err_d    = req_err;
          if (req_err) begin
            state_d = S_DONE;
          end else begin
            dm_addr_d = {req_addr[mem_size_bit-1:2], 2'b00};
            if (req_write && (req_size == 2'b10)) begin
              dmin_d  = req_wdata;
              state_d = S_WR;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: state_d = S_RDW;
      S_RDW: begin
        // DMout is valid only in this cycle: loads capture the result,
        // sub-word stores build the merged word straight into DMin.
        if (write_q) begin
          dmin_d  = store_merge(DMout, size_q, lane_q, wdata_q);
          state_d = S_WR;
        end else begin
          rdata_d = load_extract(DMout, size_q, lane_q, signed_q);
          state_d = S_DONE;
        end
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      lane_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      dm_addr_q <= '0;
      dmin_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      lane_q    <= lane_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      dm_addr_q <= dm_addr_d;
      dmin_q    <= dmin_d;
      rdata_q   <= rdata_d;
    end
  end

  // Strobes are gated by reset so an aborted request can never write or
  // complete, even in the cycle reset is first seen.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    DM_read    = reset && (state_q == S_RD);
    DM_write   = reset && (state_q == S_WR);
    DM_enable  = DM_read || DM_write;
    resp_valid = reset && (state_q == S_DONE);
    resp_error = resp_valid && err_q;
    resp_rdata = rdata_q;
    DM_address = dm_addr_q;
    DMin       = dmin_q;
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
module tb_dm_access_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic        DM_enable;
  logic        DM_read;
  logic        DM_write;
  logic [11:0] DM_address;
  logic [31:0] DMin;
  logic [31:0] DMout;

  int checks   = 0;
  int failures = 0;

  dm_access_ctrl #(.data_size(32), .mem_size_bit(12)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_error (resp_error),
    .resp_rdata (resp_rdata),
    .DM_enable  (DM_enable),
    .DM_read    (DM_read),
    .DM_write   (DM_write),
    .DM_address (DM_address),
    .DMin       (DMin),
    .DMout      (DMout)
  );

  always #5 clock = ~clock;

  // Word memory standing in for dm: one-cycle synchronous read.
  logic [31:0] mem [0:1023];
  logic        mem_clear;
  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      DMout <= '0;
    end else begin
      if (DM_enable && DM_read)  DMout <= mem[DM_address[11:2]];
      if (DM_enable && DM_write) mem[DM_address[11:2]] <= DMin;
    end
  end

  // Reference: byte-addressed memory and the last good load result.
  logic [7:0]  ref_mem [0:4095];
  logic [31:0] exp_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_err(input logic [1:0] sz, input int a);
    return (sz == 2'b11) || (sz == 2'b01 && (a % 2) != 0) || (sz == 2'b10 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit sg, input int a);
    int unsigned v;
    if (sz == 2'b00) begin
      v = ref_mem[a];
      if (sg && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      v = ref_mem[a] + 256 * ref_mem[a + 1];
      if (sg && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = ref_mem[a] + (ref_mem[a + 1] << 8) + (ref_mem[a + 2] << 16) + (ref_mem[a + 3] << 24);
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    int base;
    base = a - (a % 4);
    return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
  endfunction

  task automatic ref_store(input logic [1:0] sz, input int a, input logic [31:0] wd);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
  endtask

  // One request, observed every cycle until resp_valid (bounded).
  task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg,
                        input int a, input logic [31:0] wd);
    bit          err, got;
    int          lat, k, rd_n, wr_n, en_n, rd_k, wr_k;
    logic [31:0] din_seen, exp_word;
    err = ref_err(sz, a);
    lat = err ? 1 : !wr ? 3 : (sz == 2'b10) ? 2 : 4;
    @(negedge clock);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a[11:0]; req_wdata = wd;
    @(posedge clock);
    #1;
    req_valid = 0; req_write = $urandom; req_size = $urandom;
    req_addr = $urandom; req_wdata = $urandom;
    got = 0; k = 0; rd_n = 0; wr_n = 0; en_n = 0; rd_k = 0; wr_k = 0; din_seen = '0;
    while (!got && k < 8) begin
      @(negedge clock);
      k++;
      if (DM_enable) begin
        en_n++;
        chk("dm_address", {20'h0, DM_address}, a - (a % 4));
      end
      if (DM_enable && DM_read) begin rd_n++; rd_k = k; end
      if (DM_enable && DM_write) begin wr_n++; wr_k = k; din_seen = DMin; end
      if (resp_valid) got = 1;
    end
    if (!err && wr) ref_store(sz, a, wd);
    if (!err && !wr) exp_rdata = ref_load(sz, sg, a);
    exp_word = ref_word(a);
    chk("latency", got ? k : 99, lat);
    chk("resp_error", resp_error, err);
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("read_cycles", rd_n, (err || (wr && sz == 2'b10)) ? 0 : 1);
    chk("write_cycles", wr_n, (err || !wr) ? 0 : 1);
    if (err) chk("err_no_enable", en_n, 0);
    if (rd_n == 1) chk("read_slot", rd_k, 1);
    if (!err && wr) begin
      chk("write_slot", wr_k, lat - 1);
      chk("dmin", din_seen, exp_word);
    end
  endtask

  // Sub-word store aborted by reset during the read-data cycle.
  task automatic abort_store(input int a, input logic [31:0] wd);
    @(negedge clock);
    chk("abort_ready", req_ready, 1);
    req_valid = 1; req_write = 1; req_size = 2'b00; req_signed = 0;
    req_addr = a[11:0]; req_wdata = wd;
    @(posedge clock);
    #1 req_valid = 0;
    @(negedge clock);            // RD
    chk("abort_rd", DM_read, 1);
    @(negedge clock);            // RDW
    reset = 0;
    #1;
    chk("abort_write_now", DM_write, 0);
    chk("abort_enable_now", DM_enable, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("abort_write_later", DM_write, 0);
      chk("abort_no_resp", resp_valid, 0);
      if (i == 1) reset = 1;
    end
    chk("abort_ready_after", req_ready, 1);
    exp_rdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    exp_rdata = '0;
    mem_clear = 1;
    reset = 0;
    req_valid = 1; req_write = 1; req_size = 2'b10; req_signed = 0;
    req_addr = 12'h010; req_wdata = 32'h12345678;

    // Reset held for two cycles with a request pending.
    @(posedge clock);
    #1 mem_clear = 0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_enable", DM_enable, 0);
    chk("rst_read", DM_read, 0);
    chk("rst_write", DM_write, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_error", resp_error, 0);
    chk("rst_dm_address", {20'h0, DM_address}, 0);
    chk("rst_dmin", DMin, 0);
    chk("rst_rdata", resp_rdata, 0);
    reset = 1; req_valid = 0;
    @(negedge clock);
    chk("rst_ready_after", req_ready, 1);

    // Word store then loads of every size and signedness.
    do_req(1, 2'b10, 0, 12'h010, 32'hDEADBEEF);
    do_req(0, 2'b10, 0, 12'h010, 0);
    chk("lit_word", resp_rdata, 32'hDEADBEEF);
    do_req(0, 2'b00, 0, 12'h013, 0);
    chk("lit_byte_u", resp_rdata, 32'h000000DE);
    do_req(0, 2'b00, 1, 12'h013, 0);
    do_req(0, 2'b01, 1, 12'h012, 0);
    chk("lit_half_s", resp_rdata, 32'hFFFFDEAD);
    do_req(0, 2'b00, 1, 12'h010, 0);

    // Sub-word store by read-modify-write.
    do_req(1, 2'b00, 0, 12'h011, 32'hAAAAAA55);
    do_req(0, 2'b10, 0, 12'h010, 0);
    chk("lit_merged", resp_rdata, 32'hDEAD55EF);

    // Misaligned and illegal requests.
    do_req(0, 2'b01, 0, 12'h013, 0);
    do_req(0, 2'b10, 0, 12'h012, 0);
    do_req(0, 2'b11, 0, 12'h010, 0);
    do_req(1, 2'b01, 0, 12'h011, 32'h0000FFFF);

    // Reset during a sub-word store leaves memory untouched.
    abort_store(12'h012, 32'h00000077);
    do_req(0, 2'b10, 0, 12'h010, 0);

    // Randomised traffic over a small window so addresses collide.
    for (int i = 0; i < 80; i++) begin
      do_req($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
             $urandom_range(0, 63), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Initiator-side controller for the word-organised data memory `dm`.
- Takes byte, halfword and word load/store requests from the CPU memory stage and drives the `dm` port: DM_enable, DM_read, DM_write, DM_address and DMin.
- Captures DMout after the memory's one-cycle synchronous read.
- Performs load lane extraction with sign/zero extension.
- Performs read-modify-write for sub-word stores, because `dm` only writes whole words.

Parameters:
- data_size, 32, data word width (fixed at 32 for the lane logic).
- mem_size_bit, 12, byte-address width shared with `dm`.

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle; request accepted when req_valid && req_ready at posedge.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend loads; ignored for stores.
- req_addr  in  mem_size_bit  byte address.
- req_wdata  in  data_size  store data, low-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_error  out  1  valid with resp_valid; misaligned or illegal size.
- resp_rdata  out  data_size  load result.
- DM_enable  out  1  to `dm`.
- DM_read  out  1  to `dm`.
- DM_write  out  1  to `dm`.
- DM_address  out  mem_size_bit  to `dm`; always word-aligned ({addr[msb:2],2'b00}).
- DMin  out  data_size  to `dm`.
- DMout  in  data_size  from `dm`; valid the cycle after a read cycle.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE.
  - DM_address, DMin, resp_rdata, resp_valid, resp_error all 0.
  - DM_enable, DM_read and DM_write are forced 0 combinationally while reset==0.
- States: IDLE, RD, RDW, WR, DONE. Moore outputs:
  - RD: DM_enable=1, DM_read=1.
  - WR: DM_enable=1, DM_write=1.
  - All other states: DM_enable, DM_read and DM_write are 0.
- req_ready = (state==IDLE). Request fields are latched on acceptance. req_valid is ignored in all other states.
- Error check at acceptance: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - Go IDLE->DONE with resp_error=1.
  - No memory cycle is issued.
- Transitions, with cycle N the accept cycle:
  - Load: N+1 RD, N+2 RDW (DMout valid, captured at end of cycle), N+3 DONE.
  - Word store: N+1 WR, N+2 DONE.
  - Sub-word store: N+1 RD, N+2 RDW, N+3 WR (DMin = merged word), N+4 DONE.
  - Error: N+1 DONE.
  - DONE always goes to IDLE, so req_ready=1 at N+latency+1.
- resp_valid=1 only in DONE. resp_error=0 on good completions.
- resp_rdata:
  - Updated only on good loads.
  - Holds its value through stores, errors and idle.
- Little-endian lane selection:
  - Byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - Half lane = addr[1], bits [16*h+15 : 16*h].
- Load extension:
  - req_signed=1: replicate the lane MSB.
  - req_signed=0: zero-fill.
- Store merge:
  - Captured read word with the selected lane replaced by req_wdata[7:0] (byte) or req_wdata[15:0] (half).
  - Other lanes are unchanged.
- DM_address and DMin are registered and set on entry to RD/WR. Values in other states are don't-care.
- Reset mid-operation:
  - Any state returns to IDLE.
  - No DM_write pulse is emitted in the reset cycle or later.
  - No resp_valid for the aborted request.
- Back-to-back requests have no bubble beyond the IDLE cycle: the next request can be accepted in the first IDLE cycle after DONE.

Test Plan:
1. Hold reset=0 for 2 cycles, mid-traffic → all outputs 0; req_ready=1 on the first cycle after release.
2. Word store addr 0x010, data 0xDEADBEEF at cycle N:
   - N+1: DM_enable=1, DM_write=1, DM_address=0x010, DMin=0xDEADBEEF.
   - N+2: resp_valid=1, resp_error=0.
   - Then word load 0x010 → resp_rdata=0xDEADBEEF at accept+3.
3. With 0xDEADBEEF at 0x010, loads:
   - Byte 0x013 unsigned → 0x000000DE; signed → 0xFFFFFFDE.
   - Half 0x012 signed → 0xFFFFDEAD.
   - Byte 0x010 signed → 0xFFFFFFEF.
4. Byte store 0x55 to 0x011 over 0xDEADBEEF:
   - RD at N+1, WR at N+3 with DMin=0xDEAD55EF, resp_valid at N+4.
   - A following word load returns 0xDEAD55EF.
5. Half load 0x013, word load 0x012, and size=11 → resp_valid and resp_error at N+1, DM_enable stays 0 throughout, resp_rdata unchanged.
6. Sub-word store, with reset driven low during the RDW cycle:
   - No DM_write is asserted in that or any later cycle, and resp_valid is never asserted.
   - After release req_ready=1 and the memory word is unchanged.
